// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with direction counters, mispredict detect and stats.
// BPRED_2BIT_EN selects 2-bit saturating counters; otherwise a 1-bit last-outcome bit.
package branch_predictor_pkg;
   typedef enum logic {OPC = 1'b0, PPC = 1'b1} pred_mux_t;
endpackage

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      fetch_pc,
   output pred_mux_t        pred_sel,
   output logic [31:0]      pred_pc,
   input  logic             upd_valid,
   input  logic             upd_stall,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  pred_mux_t        upd_pred_sel,
   input  logic [31:0]      upd_pred_pc,
   output logic             mispredict,
   output logic [31:0]      recover_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX;
`ifdef BPRED_2BIT_EN
   localparam int CW = 2;
   localparam logic [CW-1:0] CNT_RST   = 2'b01;
   localparam logic [CW-1:0] CNT_ALLOC = 2'b10;
`else
   localparam int CW = 1;
   localparam logic [CW-1:0] CNT_RST   = 1'b0;
   localparam logic [CW-1:0] CNT_ALLOC = 1'b1;
`endif

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [TAG_W-1:0]   tag_d [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [31:0]        tgt_d [ENTRIES];
   logic [CW-1:0]      cnt_q [ENTRIES];
   logic [CW-1:0]      cnt_d [ENTRIES];
   logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [IDX-1:0]   f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             f_hit, u_hit, accept;
   logic [CW-1:0]    u_cnt, cnt_upd;

   assign f_idx  = fetch_pc[IDX+1:2];
   assign f_tag  = fetch_pc[31:IDX+2];
   assign u_idx  = upd_pc[IDX+1:2];
   assign u_tag  = upd_pc[31:IDX+2];
   assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign accept = upd_valid && !upd_stall;
   assign u_cnt  = cnt_q[u_idx];

   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   assign pred_sel = (f_hit && cnt_q[f_idx][CW-1]) ? PPC : OPC;
   assign pred_pc  = (pred_sel == PPC) ? tgt_q[f_idx] : fetch_pc + 32'd4;

   assign mispredict = upd_valid && ((upd_taken != (upd_pred_sel == PPC)) ||
                       (upd_taken && (upd_pred_sel == PPC) && (upd_pred_pc != upd_target)));
   assign recover_pc = upd_taken ? upd_target : upd_pc + 32'd4;

`ifdef BPRED_2BIT_EN
   assign cnt_upd = upd_taken ? ((u_cnt == 2'b11) ? u_cnt : u_cnt + 2'd1)
                              : ((u_cnt == 2'b00) ? u_cnt : u_cnt - 2'd1);
`else
   assign cnt_upd = upd_taken;
`endif

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      if (accept && u_hit) begin
         cnt_d[u_idx] = cnt_upd;
         if (upd_taken) tgt_d[u_idx] = upd_target;
      end else if (accept && upd_taken) begin
         valid_d[u_idx] = 1'b1;
         tag_d[u_idx]   = u_tag;
         tgt_d[u_idx]   = upd_target;
         cnt_d[u_idx]   = CNT_ALLOC;
      end
   end

   assign branch_cnt_d = (accept && !(&branch_cnt_q)) ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
   assign miss_cnt_d   = (accept && mispredict && !(&miss_cnt_q)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
   assign branch_cnt   = branch_cnt_q;
   assign miss_cnt     = miss_cnt_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q      <= '0;
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            cnt_q[i] <= CNT_RST;
         end
      end else begin
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         tgt_q        <= tgt_d;
         cnt_q        <= cnt_d;
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined MIPS core. Sits beside the fetch stage: each cycle it looks up the fetch PC and drives the predMux select (OPC/PPC) and predicted next PC. When a branch resolves downstream it updates the table, flags a misprediction and supplies the recovery PC that the pcMux steers through PC_BR. It also keeps saturating branch and mispredict counts for performance debug.

## Interface
- ENTRIES, 16: BTB entries; power of two, 2..256; IDX = $clog2(ENTRIES)
- CNT_W, 16: width of statistics counters
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous active-low reset
- fetch_pc  in  32  PC currently in IF
- pred_sel  out  predMux  PPC = predicted taken, OPC = sequential
- pred_pc  out  32  predicted next PC
- upd_valid  in  1  resolved branch present in the update stage
- upd_stall  in  1  update stage stalled; suppresses table/stat writes
- upd_pc  in  32  PC of resolving branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual taken target
- upd_pred_sel  in  predMux  prediction carried down the pipe for this branch
- upd_pred_pc  in  32  predicted PC carried down the pipe
- mispredict  out  1  resolved branch was mispredicted
- recover_pc  out  32  correct next PC when mispredict = 1
- branch_cnt  out  CNT_W  accepted resolved branches
- miss_cnt  out  CNT_W  accepted mispredictions

## Operation
- Entry: valid, tag = pc[31:IDX+2], target[31:0], dir counter. Index = pc[IDX+1:2].
- Lookup (combinational): hit = valid & tag match at fetch_pc index. pred_sel = PPC iff hit & counter MSB = 1; pred_pc = target if PPC, else fetch_pc + 4 (32-bit wrap, 0xFFFFFFFC + 4 = 0).
- Accept = upd_valid & !upd_stall. Writes occur only on an accepted update.
- Update, entry hits upd_pc: taken → counter +1 saturating at 2'b11 and target ← upd_target; not taken → counter −1 saturating at 2'b00, target unchanged.
- Update, entry misses: taken → allocate (valid = 1, tag, target, counter = 2'b10), evicting any occupant; not taken → no change.
- mispredict = upd_valid & ((upd_taken ≠ (upd_pred_sel == PPC)) | (upd_taken & upd_pred_sel == PPC & upd_pred_pc ≠ upd_target)). It is combinational and asserted regardless of upd_stall; the consumer qualifies it.
- recover_pc = upd_taken ? upd_target : upd_pc + 4.
- Statistics: on accept, branch_cnt +1; if mispredict, miss_cnt +1. Both saturate at all-ones and do not wrap.

## Timing
- Lookup has zero latency. An update becomes visible to lookup on the cycle after the accepting edge.
- Same-index lookup and update in one cycle: the lookup sees the pre-update contents (no bypass).
- Reset (asynchronous, at any time, including mid-update): all valid = 0, counters = 2'b01, targets = 0, branch_cnt = miss_cnt = 0. After reset, pred_sel = OPC and pred_pc = fetch_pc + 4. mispredict and recover_pc follow their inputs combinationally.
- Any update in flight when reset asserts is discarded.
- No state changes while upd_stall = 1, so a repeated stalled update counts once.

## Configuration
- BPRED_2BIT_EN defined: 2-bit saturating counters as above.
- BPRED_2BIT_EN undefined: 1-bit last-outcome counter.
  - Reset value 0; allocation sets 1.
  - A hit stores upd_taken.
  - Prediction is that bit.
  - All other behaviour is unchanged.

## Test plan
- Reset, fetch_pc = 0x0040 → pred_sel = OPC, pred_pc = 0x0044, branch_cnt = miss_cnt = 0.
- Accepted update upd_pc = 0x0040, taken, target 0x0100, pred OPC → mispredict = 1, recover_pc = 0x0100. Next cycle, fetch 0x0040 → PPC, pred_pc = 0x0100; miss_cnt = 1.
- With 2-bit counters, same branch taken, then not-taken twice → prediction goes PPC, PPC, OPC. With BPRED_2BIT_EN undefined → OPC after the first not-taken.
- Alias: ENTRIES = 16, 0x0040 allocated, then taken update at 0x0080 (same index) → fetch 0x0040 = OPC, fetch 0x0080 = PPC.
- upd_valid = 1 held with upd_stall = 1 for 3 cycles, then released → branch_cnt increments by exactly 1. Same-cycle lookup of the updating index returns the old prediction.
- Force branch_cnt to all-ones (CNT_W = 4, 16 updates) → it holds at 0xF. nRST pulsed mid-update → all entries invalid, counts 0 immediately.
